// File: rtl/dcache_dm_pkg.sv
// Shared encodings for the direct-mapped write-through data cache: FSM states
// and the EX-stage access width codes.
package dcache_dm_pkg;

    typedef enum logic [1:0] {
        DC_IDLE   = 2'b00,
        DC_REFILL = 2'b01,
        DC_WRITE  = 2'b10,
        DC_DONE   = 2'b11
    } dc_state_t;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

endpackage

// File: rtl/dcache_dm_wstrb_gen.sv
// Store lane steering: turns width + byte offset + LSB-aligned data into bus
// byte strobes and lane-replicated write data.
module dcache_wstrb_gen
    import dcache_dm_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    // NOTE: every output gets a value on every path through the case, so no latch is inferred.
    always_comb begin
        case (width)
            MEM_BYTE: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            MEM_HALF: begin
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{data[15:0]}};
            end
            default: begin
                wstrb = 4'hF;
                wdata = data;
            end
        endcase
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with single-beat
// word bus refill. Optional hit/miss counters under DCACHE_PERF_CNT_EN.
module dcache_dm
    import dcache_dm_pkg::*;
#(
    parameter int LINES = 64,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_req_Dcache_i,
    input  logic        ex_mem_rw_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic [1:0]  ex_mem_wrwidth_i,
    input  logic [31:0] ex_mem_wr_data_i,
    output logic [31:0] Dcache_rdata_o,
    output logic        Dcache_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ready_i,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0] perf_hit_o,
    output logic [31:0] perf_miss_o,
`endif
    input  logic [31:0] mem_rdata_i
);

    localparam int WI_W  = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - WI_W - IDX_W;

    dc_state_t               state_q;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [31:0]             data_q [LINES*WORDS];
    logic [31:2]             addr_q;
    logic                    rw_q;
    logic [WI_W-1:0]         beat_q;
    logic [WI_W-1:0]         beat_nxt;

    logic [31:2]             lk_addr;
    logic [TAG_W-1:0]        lk_tag;
    logic [IDX_W-1:0]        lk_idx;
    logic [WI_W-1:0]         lk_wi;
    logic                    lk_hit;
    logic [31:0]             lk_word;
    logic                    load_hit;
    logic                    tag_we;
    logic                    store_done;
    logic                    dw_en;
    logic [IDX_W+WI_W-1:0]   dw_idx;
    logic [31:0]             dw_data;
    logic [3:0]              gen_wstrb;
    logic [31:0]             gen_wdata;

    dcache_wstrb_gen u_wstrb_gen (
        .width   (ex_mem_wrwidth_i),
        .addr_lo (ex_mem_addr_i[1:0]),
        .data    (ex_mem_wr_data_i),
        .wstrb   (gen_wstrb),
        .wdata   (gen_wdata)
    );

    // Lookups use the live EX address in IDLE and the captured one while busy.
    assign lk_addr    = (state_q == DC_IDLE) ? ex_mem_addr_i[31:2] : addr_q;
    assign lk_tag     = lk_addr[31 -: TAG_W];
    assign lk_idx     = lk_addr[2+WI_W +: IDX_W];
    assign lk_wi      = lk_addr[2 +: WI_W];
    assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_word    = data_q[{lk_idx, lk_wi}];
    assign beat_nxt   = beat_q + WI_W'(1);

    assign load_hit   = (state_q == DC_IDLE) && ex_req_Dcache_i && !ex_mem_rw_i && lk_hit;
    assign tag_we     = (state_q == DC_IDLE) && ex_req_Dcache_i && !ex_mem_rw_i && !lk_hit;
    assign store_done = (state_q == DC_WRITE) && mem_ready_i;

    assign Dcache_stall_o = ex_req_Dcache_i && !load_hit && (state_q != DC_DONE);

    always_comb begin
        Dcache_rdata_o = '0;
        if (load_hit || (state_q == DC_DONE && !rw_q))
            Dcache_rdata_o = lk_word;
    end

    // Single array write port: refill beats or a byte-merged store hit.
    always_comb begin
        dw_en   = 1'b0;
        dw_idx  = {lk_idx, beat_q};
        dw_data = mem_rdata_i;
        if (state_q == DC_REFILL && mem_ready_i) begin
            dw_en = 1'b1;
        end else if (store_done && lk_hit) begin
            dw_en  = 1'b1;
            dw_idx = {lk_idx, lk_wi};
            for (int b = 0; b < 4; b++)
                dw_data[8*b +: 8] = mem_wstrb_o[b] ? mem_wdata_o[8*b +: 8] : lk_word[8*b +: 8];
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide what is usable.
    always_ff @(posedge clk) begin
        if (tag_we)
            tag_q[lk_idx] <= lk_tag;
        if (dw_en)
            data_q[dw_idx] <= dw_data;
    end

    // NOTE: all state here is sequential, so only non-blocking assignments are used.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DC_IDLE;
            valid_q     <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            beat_q      <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end else begin
            case (state_q)
                DC_IDLE: begin
                    if (ex_req_Dcache_i && !load_hit) begin
                        addr_q <= ex_mem_addr_i[31:2];
                        rw_q   <= ex_mem_rw_i;
                        if (ex_mem_rw_i) begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= {ex_mem_addr_i[31:2], 2'b00};
                            mem_wstrb_o <= gen_wstrb;
                            mem_wdata_o <= gen_wdata;
                            state_q     <= DC_WRITE;
                        end else begin
                            valid_q[lk_idx] <= 1'b0;
                            beat_q          <= '0;
                            mem_req_o       <= 1'b1;
                            mem_we_o        <= 1'b0;
                            mem_addr_o      <= {lk_tag, lk_idx, {WI_W{1'b0}}, 2'b00};
                            state_q         <= DC_REFILL;
                        end
                    end
                end
                DC_REFILL: begin
                    if (mem_ready_i) begin
                        beat_q <= beat_nxt;
                        if (beat_q == WI_W'(WORDS - 1)) begin
                            valid_q[lk_idx] <= 1'b1;
                            mem_req_o       <= 1'b0;
                            mem_addr_o      <= '0;
                            state_q         <= DC_DONE;
                        end else begin
                            mem_addr_o <= {lk_tag, lk_idx, beat_nxt, 2'b00};
                        end
                    end
                end
                DC_WRITE: begin
                    if (mem_ready_i) begin
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                        mem_wstrb_o <= '0;
                        state_q     <= DC_DONE;
                    end
                end
                default: state_q <= DC_IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hit_o  <= '0;
            perf_miss_o <= '0;
        end else begin
            if (load_hit || (store_done && lk_hit))
                perf_hit_o <= perf_hit_o + 32'd1;
            if (tag_we || (store_done && !lk_hit))
                perf_miss_o <= perf_miss_o + 32'd1;
        end
    end
`endif

endmodule
